// File: rtl/bus_arb3.sv
`default_nettype none
// ============================================================================
// Module      : bus_arb3
// Description : Three-requester round-robin bus arbiter with per-ownership
//               hold timeout, one-cycle turnaround after every grant, and a
//               timeout mask that blocks a revoked master until it lets go.
// Revision    : 1.0 - initial release
// ============================================================================
module bus_arb3 #(
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] req,
    output logic [2:0] gnt,
    output logic [1:0] owner,
    output logic       busy,
    output logic       timeout
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_TURN  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);

    state_t           r_state;
    state_t           w_state_n;
    logic [1:0]       r_ptr;
    logic [1:0]       w_ptr_n;
    logic [2:0]       r_mask;
    logic [2:0]       w_mask_n;
    logic [2:0]       w_mask_set;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_n;
    logic [2:0]       w_gnt_n;
    logic [1:0]       w_owner_n;
    logic             w_timeout_n;

    logic [2:0]       w_elig;
    logic             w_pick_vld;
    logic [1:0]       w_pick;
    logic [1:0]       w_owner_next;

    assign w_elig       = req & ~r_mask;
    assign w_owner_next = (owner == 2'd2) ? 2'd0 : owner + 2'd1;

    // Round-robin pick: first eligible requester starting at the pointer.
    always_comb begin
        w_pick_vld = 1'b0;
        w_pick     = 2'd0;
        case (r_ptr)
            2'd1: begin
                if      (w_elig[1]) begin w_pick_vld = 1'b1; w_pick = 2'd1; end
                else if (w_elig[2]) begin w_pick_vld = 1'b1; w_pick = 2'd2; end
                else if (w_elig[0]) begin w_pick_vld = 1'b1; w_pick = 2'd0; end
            end
            2'd2: begin
                if      (w_elig[2]) begin w_pick_vld = 1'b1; w_pick = 2'd2; end
                else if (w_elig[0]) begin w_pick_vld = 1'b1; w_pick = 2'd0; end
                else if (w_elig[1]) begin w_pick_vld = 1'b1; w_pick = 2'd1; end
            end
            default: begin
                if      (w_elig[0]) begin w_pick_vld = 1'b1; w_pick = 2'd0; end
                else if (w_elig[1]) begin w_pick_vld = 1'b1; w_pick = 2'd1; end
                else if (w_elig[2]) begin w_pick_vld = 1'b1; w_pick = 2'd2; end
            end
        endcase
    end

    // Next-state and next-output logic; release wins over timeout.
    always_comb begin
        w_state_n   = r_state;
        w_gnt_n     = gnt;
        w_owner_n   = owner;
        w_cnt_n     = r_cnt;
        w_ptr_n     = r_ptr;
        w_timeout_n = 1'b0;
        w_mask_set  = 3'b000;
        case (r_state)
            S_GRANT: begin
                w_cnt_n = r_cnt + c_cnt_one;
                if (!req[owner]) begin
                    w_gnt_n   = 3'b000;
                    w_ptr_n   = w_owner_next;
                    w_state_n = S_TURN;
                end else if (r_cnt == c_cnt_last) begin
                    w_gnt_n            = 3'b000;
                    w_timeout_n        = 1'b1;
                    w_mask_set[owner]  = 1'b1;
                    w_ptr_n            = w_owner_next;
                    w_state_n          = S_TURN;
                end
            end
            default: begin
                // IDLE and TURN arbitrate identically; TURN only exists to
                // force the one dead cycle between owners.
                w_gnt_n = 3'b000;
                if (w_pick_vld) begin
                    w_gnt_n   = 3'b001 << w_pick;
                    w_owner_n = w_pick;
                    w_cnt_n   = '0;
                    w_state_n = S_GRANT;
                end else begin
                    w_state_n = S_IDLE;
                end
            end
        endcase
        // A mask bit survives only while its request stays high.
        w_mask_n = (r_mask & req) | w_mask_set;
    end

    // State, pointer, mask, counter and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_ptr   <= 2'd0;
            r_mask  <= 3'b000;
            r_cnt   <= '0;
            gnt     <= 3'b000;
            owner   <= 2'd0;
            timeout <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_ptr   <= w_ptr_n;
            r_mask  <= w_mask_n;
            r_cnt   <= w_cnt_n;
            gnt     <= w_gnt_n;
            owner   <= w_owner_n;
            timeout <= w_timeout_n;
        end
    end

    assign busy = |gnt;

endmodule
`default_nettype wire

// File: tb/tb_bus_arb3.sv
`default_nettype none
// ============================================================================
// Module      : tb_bus_arb3
// Description : Directed self-checking bench for bus_arb3 with TIMEOUT=4.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bus_arb3;

    localparam int TO = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] req;
    logic [2:0] gnt;
    logic [1:0] owner;
    logic       busy;
    logic       timeout;

    int vectors    = 0;
    int miscompares = 0;

    bus_arb3 #(.TIMEOUT(TO), .CNT_W(8)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .gnt     (gnt),
        .owner   (owner),
        .busy    (busy),
        .timeout (timeout)
    );

    always #5 clk = ~clk;

    // Advance one rising edge and settle before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req   = 3'b000;
        tick();
        tick();
        vectors++;
        if (gnt !== 3'b000) begin miscompares++; $display("FAIL reset_gnt got %b want 000", gnt); end
        vectors++;
        if (owner !== 2'd0) begin miscompares++; $display("FAIL reset_owner got %0d want 0", owner); end
        vectors++;
        if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", busy); end
        vectors++;
        if (timeout !== 1'b0) begin miscompares++; $display("FAIL reset_timeout got %b want 0", timeout); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_release();
        req = 3'b001;
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++;
            if (gnt !== 3'b001 || owner !== 2'd0 || busy !== 1'b1) begin
                miscompares++;
                $display("FAIL rel_grant[%0d] got gnt=%b owner=%0d busy=%b want 001/0/1", i, gnt, owner, busy);
            end
        end
        req = 3'b000;
        tick();
        vectors++;
        if (gnt !== 3'b000 || busy !== 1'b0 || owner !== 2'd0 || timeout !== 1'b0) begin
            miscompares++;
            $display("FAIL rel_turn got gnt=%b busy=%b owner=%0d to=%b want 000/0/0/0", gnt, busy, owner, timeout);
        end
        tick();
        vectors++;
        if (gnt !== 3'b000) begin miscompares++; $display("FAIL rel_idle got %b want 000", gnt); end
        // ptr is now 1: search order 1,2,0, so 2 beats 0.
        req = 3'b101;
        tick();
        vectors++;
        if (gnt !== 3'b100 || owner !== 2'd2) begin
            miscompares++;
            $display("FAIL rel_ptr got gnt=%b owner=%0d want 100/2", gnt, owner);
        end
        req = 3'b000;
        tick();
        tick();
    endtask

    task automatic test_timeout_rr();
        logic [2:0] exp_g;
        req = 3'b111;
        for (int g = 0; g < 3; g++) begin
            exp_g = 3'b001 << g;
            for (int c = 0; c < TO; c++) begin
                tick();
                vectors++;
                if (gnt !== exp_g || owner !== 2'(g) || timeout !== 1'b0) begin
                    miscompares++;
                    $display("FAIL rr_grant g=%0d c=%0d got gnt=%b owner=%0d to=%b want %b/%0d/0",
                             g, c, gnt, owner, timeout, exp_g, g);
                end
            end
            tick();
            vectors++;
            if (gnt !== 3'b000 || timeout !== 1'b1) begin
                miscompares++;
                $display("FAIL rr_revoke g=%0d got gnt=%b to=%b want 000/1", g, gnt, timeout);
            end
        end
        // All three masked while req stays high: idle, no more pulses.
        for (int c = 0; c < 4; c++) begin
            tick();
            vectors++;
            if (gnt !== 3'b000 || timeout !== 1'b0 || owner !== 2'd2) begin
                miscompares++;
                $display("FAIL rr_masked c=%0d got gnt=%b to=%b owner=%0d want 000/0/2", c, gnt, timeout, owner);
            end
        end
        req = 3'b000;
        tick();
        tick();
    endtask

    task automatic test_release_at_timeout();
        // ptr is 0 here.
        req = 3'b001;
        for (int c = 0; c < TO; c++) begin
            tick();
            vectors++;
            if (gnt !== 3'b001) begin miscompares++; $display("FAIL rat_grant c=%0d got %b want 001", c, gnt); end
        end
        // Now in the cnt==TIMEOUT-1 cycle: drop the request.
        req = 3'b000;
        tick();
        vectors++;
        if (gnt !== 3'b000 || timeout !== 1'b0) begin
            miscompares++;
            $display("FAIL rat_release got gnt=%b to=%b want 000/0", gnt, timeout);
        end
        req = 3'b001;
        tick();
        vectors++;
        if (gnt !== 3'b001 || owner !== 2'd0) begin
            miscompares++;
            $display("FAIL rat_regrant got gnt=%b owner=%0d want 001/0", gnt, owner);
        end
        req = 3'b000;
        tick();
        tick();
    endtask

    task automatic test_mask_clear();
        // ptr is 1 here.
        req = 3'b010;
        for (int c = 0; c < TO; c++) begin
            tick();
            vectors++;
            if (gnt !== 3'b010 || owner !== 2'd1) begin
                miscompares++;
                $display("FAIL mask_grant c=%0d got gnt=%b owner=%0d want 010/1", c, gnt, owner);
            end
        end
        tick();
        vectors++;
        if (gnt !== 3'b000 || timeout !== 1'b1) begin
            miscompares++;
            $display("FAIL mask_revoke got gnt=%b to=%b want 000/1", gnt, timeout);
        end
        for (int c = 0; c < 2; c++) begin
            tick();
            vectors++;
            if (gnt !== 3'b000 || timeout !== 1'b0) begin
                miscompares++;
                $display("FAIL mask_held c=%0d got gnt=%b to=%b want 000/0", c, gnt, timeout);
            end
        end
        req = 3'b000;
        tick();
        vectors++;
        if (gnt !== 3'b000) begin miscompares++; $display("FAIL mask_drop got %b want 000", gnt); end
        // Mask cleared by the low cycle; the reassert is eligible at the next edge.
        req = 3'b010;
        tick();
        vectors++;
        if (gnt !== 3'b010 || owner !== 2'd1 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL mask_regrant got gnt=%b owner=%0d busy=%b want 010/1/1", gnt, owner, busy);
        end
        req = 3'b000;
        tick();
        tick();
    endtask

    task automatic test_async_reset();
        // ptr is 2 here; only requester 1 is asking.
        req = 3'b010;
        tick();
        tick();
        vectors++;
        if (gnt !== 3'b010) begin miscompares++; $display("FAIL arst_pre got %b want 010", gnt); end
        #3;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (gnt !== 3'b000 || busy !== 1'b0 || owner !== 2'd0 || timeout !== 1'b0) begin
            miscompares++;
            $display("FAIL arst_drop got gnt=%b busy=%b owner=%0d to=%b want 000/0/0/0", gnt, busy, owner, timeout);
        end
        req = 3'b110;
        tick();
        rst_n = 1'b1;
        tick();
        vectors++;
        if (gnt !== 3'b010 || owner !== 2'd1) begin
            miscompares++;
            $display("FAIL arst_ptr got gnt=%b owner=%0d want 010/1", gnt, owner);
        end
        req = 3'b000;
        tick();
        tick();
    endtask

    task automatic test_back_to_back();
        // ptr is 2 after the previous release of owner 1.
        req = 3'b011;
        tick();
        vectors++;
        if (gnt !== 3'b001) begin miscompares++; $display("FAIL b2b_first got %b want 001", gnt); end
        // Owner 0 releases; requester 1 takes over after exactly one dead cycle.
        req = 3'b010;
        tick();
        vectors++;
        if (gnt !== 3'b000) begin miscompares++; $display("FAIL b2b_turn got %b want 000", gnt); end
        tick();
        vectors++;
        if (gnt !== 3'b010 || owner !== 2'd1) begin
            miscompares++;
            $display("FAIL b2b_second got gnt=%b owner=%0d want 010/1", gnt, owner);
        end
        // Non-owner request toggles have no effect mid-grant.
        req = 3'b111;
        tick();
        vectors++;
        if (gnt !== 3'b010) begin miscompares++; $display("FAIL b2b_hold got %b want 010", gnt); end
        req = 3'b000;
        tick();
        tick();
    endtask

    initial begin
        test_reset();
        test_release();
        test_timeout_rr();
        test_release_at_timeout();
        test_mask_clear();
        test_async_reset();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

endmodule
`default_nettype wire
